// File: rtl/zrb_spi_slave_if.sv
// Bus bundle for zrb_spi_slave: SPI pins plus the host-side TX/RX handshake.
interface zrb_spi_slave_if #(
  parameter int NUM_BITS = 8
);
  logic                sck;
  logic                cs_n;
  logic                mosi;
  logic                miso;
  logic                miso_oe;
  logic [NUM_BITS-1:0] tx_data;
  logic                tx_wr;
  logic                tx_ready;
  logic [NUM_BITS-1:0] rx_data;
  logic                rx_valid;
  logic                rx_rd;
  logic                rx_overrun;
  logic                busy;

  modport slave (
    input  sck, cs_n, mosi, tx_data, tx_wr, rx_rd,
    output miso, miso_oe, tx_ready, rx_data, rx_valid, rx_overrun, busy
  );

  modport master (
    output sck, cs_n, mosi, tx_data, tx_wr, rx_rd,
    input  miso, miso_oe, tx_ready, rx_data, rx_valid, rx_overrun, busy
  );
endinterface

// File: rtl/zrb_spi_slave.sv
// SPI mode-0 target with oversampled bus inputs, one-entry TX holding and RX registers.
// Optional ZRB_SPI_SLAVE_ECHO_EN: an empty TX slot sends the last received byte instead of FILL.
module zrb_spi_slave #(
  parameter int                  NUM_BITS    = 8,
  parameter int                  SYNC_STAGES = 2,
  parameter logic [NUM_BITS-1:0] FILL        = {NUM_BITS{1'b1}}
) (
  input logic              clk,
  input logic              reset,
  zrb_spi_slave_if.slave   bus
);
  localparam int             CW       = $clog2(NUM_BITS + 1);
  localparam logic [CW-1:0]  CNT_FULL = CW'(NUM_BITS);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
  logic                   sck_d, cs_d;
  logic                   sck_s, cs_s, mosi_s;
  logic                   sck_rise, sck_fall, cs_rise, cs_fall;

  logic [NUM_BITS-1:0] tx_sh, rx_sh, hold_q, rx_data_q, load_val;
  logic                hold_full, rx_valid_q, rx_overrun_q, miso_q;
  logic [CW-1:0]       cnt;
  logic                frame_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_sync  <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], bus.sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      sck_d     <= sck_s;
      cs_d      <= cs_s;
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign cs_rise  = cs_s & ~cs_d;
  assign cs_fall  = ~cs_s & cs_d;

  // Completion is seen the cycle after the last rising edge drains the counter.
  assign frame_done = (state == SHIFT) && (cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (cs_fall) state_nxt = LOAD;
      LOAD:    state_nxt = SHIFT;
      SHIFT:   if (frame_done) state_nxt = cs_s ? IDLE : LOAD;
      default: state_nxt = IDLE;
    endcase
    if (cs_rise) state_nxt = IDLE;
  end

`ifdef ZRB_SPI_SLAVE_ECHO_EN
  logic [NUM_BITS-1:0] echo_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           echo_q <= FILL;
    else if (frame_done) echo_q <= rx_sh;
  end

  assign load_val = hold_full ? hold_q : echo_q;
`else
  assign load_val = hold_full ? hold_q : FILL;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_sh        <= '0;
      rx_sh        <= '0;
      cnt          <= '0;
      miso_q       <= 1'b1;
      hold_q       <= '0;
      hold_full    <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else begin
      rx_overrun_q <= 1'b0;

      if (state == LOAD) begin
        tx_sh  <= load_val;
        miso_q <= load_val[NUM_BITS-1];
        cnt    <= CNT_FULL;
      end else if (state == SHIFT) begin
        if (sck_rise && cnt != '0) begin
          rx_sh <= {rx_sh[NUM_BITS-2:0], mosi_s};
          cnt   <= cnt - CW'(1);
        end
        // A full counter means no rise yet this frame, so a fall here is the
        // trailing edge of the previous frame and must not shift.
        if (sck_fall && cnt != CNT_FULL) begin
          tx_sh  <= tx_sh << 1;
          miso_q <= tx_sh[NUM_BITS-2];
        end
      end

      if (state == LOAD && hold_full) begin
        hold_full <= 1'b0;
      end else if (bus.tx_wr && !hold_full) begin
        hold_q    <= bus.tx_data;
        hold_full <= 1'b1;
      end

      if (bus.rx_rd && rx_valid_q) rx_valid_q <= 1'b0;
      if (frame_done) begin
        if (!rx_valid_q || bus.rx_rd) begin
          rx_data_q  <= rx_sh;
          rx_valid_q <= 1'b1;
        end else begin
          rx_overrun_q <= 1'b1;
        end
      end
    end
  end

  assign bus.miso       = miso_q;
  assign bus.miso_oe    = ~cs_s;
  assign bus.tx_ready   = ~hold_full;
  assign bus.rx_data    = rx_data_q;
  assign bus.rx_valid   = rx_valid_q;
  assign bus.rx_overrun = rx_overrun_q;
  assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_zrb_spi_slave.sv
// Bench for zrb_spi_slave: bit-banged SPI master plus a queue/flag model of the TX/RX slots.
module tb_zrb_spi_slave;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  zrb_spi_slave_if #(.NUM_BITS(8)) bus();

  zrb_spi_slave #(.NUM_BITS(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int total = 0;
  int bad = 0;
  int ov_cnt = 0;
  logic [7:0] m_echo = 8'hFF;   // last fully received byte, as the model sees it

  always @(negedge clk) if (bus.rx_overrun === 1'b1) ov_cnt++;

  function automatic logic [7:0] dflt();
`ifdef ZRB_SPI_SLAVE_ECHO_EN
    return m_echo;
`else
    return 8'hFF;
`endif
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_tx(input logic [7:0] d);
    bus.tx_data = d; bus.tx_wr = 1'b1; tick(1); bus.tx_wr = 1'b0;
  endtask

  task automatic read_rx();
    bus.rx_rd = 1'b1; tick(1); bus.rx_rd = 1'b0;
  endtask

  // Eight SCK cycles, 4 clk high / 4 clk low; miso sampled at each rise.
  task automatic shift_byte(input logic [7:0] mo, input bit rd_last, output logic [7:0] mi);
    mi = '0;
    for (int i = 7; i >= 0; i--) begin
      bus.mosi = mo[i];
      bus.sck = 1'b1;
      mi[i] = bus.miso;
      if (i == 0 && rd_last) begin
        tick(3); bus.rx_rd = 1'b1; tick(1); bus.rx_rd = 1'b0;
      end else begin
        tick(4);
      end
      bus.sck = 1'b0;
      tick(4);
    end
  endtask

  task automatic frame(input logic [7:0] mo, input bit rd_last, output logic [7:0] mi);
    bus.cs_n = 1'b0; tick(6);
    shift_byte(mo, rd_last, mi);
    tick(3); bus.cs_n = 1'b1; tick(6);
    m_echo = mo;
  endtask

  task automatic test_reset();
    tick(3);
    total++; if (bus.miso !== 1'b1) begin bad++; $display("FAIL reset_miso got %b exp 1", bus.miso); end
    total++; if (bus.miso_oe !== 1'b0) begin bad++; $display("FAIL reset_miso_oe got %b exp 0", bus.miso_oe); end
    total++; if (bus.tx_ready !== 1'b1) begin bad++; $display("FAIL reset_tx_ready got %b exp 1", bus.tx_ready); end
    total++; if (bus.rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data got %h exp 00", bus.rx_data); end
    total++; if (bus.rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid got %b exp 0", bus.rx_valid); end
    total++; if (bus.rx_overrun !== 1'b0) begin bad++; $display("FAIL reset_rx_overrun got %b exp 0", bus.rx_overrun); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    reset = 1'b0; tick(2);
  endtask

  task automatic test_single();
    logic [7:0] mi;
    write_tx(8'hA5);
    total++; if (bus.tx_ready !== 1'b0) begin bad++; $display("FAIL single_tx_ready_low got %b exp 0", bus.tx_ready); end
    frame(8'h3C, 1'b0, mi);
    total++; if (mi !== 8'hA5) begin bad++; $display("FAIL single_miso got %h exp a5", mi); end
    total++; if (bus.rx_data !== 8'h3C) begin bad++; $display("FAIL single_rx_data got %h exp 3c", bus.rx_data); end
    total++; if (bus.rx_valid !== 1'b1) begin bad++; $display("FAIL single_rx_valid got %b exp 1", bus.rx_valid); end
    total++; if (bus.tx_ready !== 1'b1) begin bad++; $display("FAIL single_tx_ready got %b exp 1", bus.tx_ready); end
    read_rx();
    total++; if (bus.rx_valid !== 1'b0) begin bad++; $display("FAIL single_rx_clear got %b exp 0", bus.rx_valid); end
  endtask

  task automatic test_empty_tx();
    logic [7:0] mi, exp;
    exp = dflt();
    frame(8'h12, 1'b0, mi);
    total++; if (mi !== exp) begin bad++; $display("FAIL empty_miso1 got %h exp %h", mi, exp); end
    read_rx();
    exp = dflt();
    frame(8'h34, 1'b0, mi);
    total++; if (mi !== exp) begin bad++; $display("FAIL empty_miso2 got %h exp %h", mi, exp); end
    total++; if (bus.rx_data !== 8'h34) begin bad++; $display("FAIL empty_rx_data got %h exp 34", bus.rx_data); end
    read_rx();
  endtask

  task automatic test_overrun();
    logic [7:0] mi;
    int ov0;
    ov0 = ov_cnt;
    frame(8'h01, 1'b0, mi);
    frame(8'h02, 1'b0, mi);
    total++; if (bus.rx_data !== 8'h01) begin bad++; $display("FAIL overrun_rx_data got %h exp 01", bus.rx_data); end
    total++; if (ov_cnt - ov0 !== 1) begin bad++; $display("FAIL overrun_pulses got %0d exp 1", ov_cnt - ov0); end
    ov0 = ov_cnt;
    frame(8'h02, 1'b1, mi);
    total++; if (bus.rx_data !== 8'h02) begin bad++; $display("FAIL coincident_rx_data got %h exp 02", bus.rx_data); end
    total++; if (bus.rx_valid !== 1'b1) begin bad++; $display("FAIL coincident_rx_valid got %b exp 1", bus.rx_valid); end
    total++; if (ov_cnt - ov0 !== 0) begin bad++; $display("FAIL coincident_pulses got %0d exp 0", ov_cnt - ov0); end
    read_rx();
  endtask

  task automatic test_back_to_back();
    logic [7:0] mi1, mi2;
    logic [7:0] got[$];
    bit done;
    done = 1'b0;
    write_tx(8'h0F);
    fork
      begin
        bus.cs_n = 1'b0; tick(6);
        write_tx(8'hF0);
        shift_byte(8'h55, 1'b0, mi1);
        shift_byte(8'hAA, 1'b0, mi2);
        tick(3); bus.cs_n = 1'b1; tick(6);
        done = 1'b1;
      end
      begin
        int g;
        g = 0;
        while (!done && g < 1000) begin
          tick(1); g++;
          if (bus.rx_valid === 1'b1) begin
            got.push_back(bus.rx_data);
            bus.rx_rd = 1'b1; tick(1); bus.rx_rd = 1'b0;
          end
        end
      end
    join
    m_echo = 8'hAA;
    total++; if (mi1 !== 8'h0F) begin bad++; $display("FAIL b2b_miso1 got %h exp 0f", mi1); end
    total++; if (mi2 !== 8'hF0) begin bad++; $display("FAIL b2b_miso2 got %h exp f0", mi2); end
    total++; if (got.size() !== 2) begin bad++; $display("FAIL b2b_rx_events got %0d exp 2", got.size()); end
    else begin
      total++; if (got[0] !== 8'h55 || got[1] !== 8'hAA) begin
        bad++; $display("FAIL b2b_rx_bytes got %h %h exp 55 aa", got[0], got[1]);
      end
    end
  endtask

  task automatic test_abort();
    logic [7:0] mi, exp;
    write_tx(8'hC3);
    bus.cs_n = 1'b0; tick(6);
    for (int i = 0; i < 2; i++) begin
      bus.mosi = 1'($urandom); bus.sck = 1'b1; tick(4); bus.sck = 1'b0; tick(4);
    end
    bus.cs_n = 1'b1; tick(4);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort_busy got %b exp 0", bus.busy); end
    total++; if (bus.miso_oe !== 1'b0) begin bad++; $display("FAIL abort_miso_oe got %b exp 0", bus.miso_oe); end
    total++; if (bus.rx_valid !== 1'b0) begin bad++; $display("FAIL abort_rx_valid got %b exp 0", bus.rx_valid); end
    total++; if (bus.tx_ready !== 1'b1) begin bad++; $display("FAIL abort_tx_ready got %b exp 1", bus.tx_ready); end
    tick(4);
    exp = dflt();
    frame(8'h66, 1'b0, mi);
    total++; if (mi !== exp) begin bad++; $display("FAIL abort_next_miso got %h exp %h", mi, exp); end
    total++; if (bus.rx_data !== 8'h66) begin bad++; $display("FAIL abort_next_rx got %h exp 66", bus.rx_data); end
    read_rx();
  endtask

  task automatic test_reset_midframe();
    logic [7:0] mi;
    write_tx(8'h77);
    bus.cs_n = 1'b0; tick(6);
    for (int i = 0; i < 3; i++) begin
      bus.mosi = 1'($urandom); bus.sck = 1'b1; tick(4); bus.sck = 1'b0; tick(4);
    end
    bus.mosi = 1'b1; bus.sck = 1'b1;
    #2 reset = 1'b1;
    #1;
    total++; if (bus.miso !== 1'b1) begin bad++; $display("FAIL rstmid_miso got %b exp 1", bus.miso); end
    total++; if (bus.miso_oe !== 1'b0) begin bad++; $display("FAIL rstmid_miso_oe got %b exp 0", bus.miso_oe); end
    total++; if (bus.tx_ready !== 1'b1) begin bad++; $display("FAIL rstmid_tx_ready got %b exp 1", bus.tx_ready); end
    total++; if (bus.rx_data !== 8'h00) begin bad++; $display("FAIL rstmid_rx_data got %h exp 00", bus.rx_data); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got %b exp 0", bus.busy); end
    bus.sck = 1'b0; bus.cs_n = 1'b1;
    tick(2); reset = 1'b0; tick(4);
    m_echo = 8'hFF;
    frame(8'h9A, 1'b0, mi);
    total++; if (mi !== 8'hFF) begin bad++; $display("FAIL rstmid_next_miso got %h exp ff", mi); end
    total++; if (bus.rx_data !== 8'h9A || bus.rx_valid !== 1'b1) begin
      bad++; $display("FAIL rstmid_next_rx got %h/%b exp 9a/1", bus.rx_data, bus.rx_valid);
    end
    read_rx();
  endtask

  // Random mix of writes, double writes, reads, coincident reads and overruns.
  task automatic test_random();
    logic [7:0] mi, mo, d, exp_mi, m_rx;
    bit m_valid, m_hold_full, rd_last;
    logic [7:0] m_hold;
    int ov0, exp_ov;
    m_valid = 1'b0; m_hold_full = 1'b0; m_hold = '0; m_rx = bus.rx_data;
    read_rx();
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(1, 0) == 1) begin
        d = 8'($urandom); write_tx(d);
        m_hold = d; m_hold_full = 1'b1;
        if ($urandom_range(1, 0) == 1) write_tx(8'($urandom));
        total++; if (bus.tx_ready !== 1'b0) begin bad++; $display("FAIL rand_tx_ready it=%0d got %b exp 0", it, bus.tx_ready); end
      end
      mo = 8'($urandom);
      rd_last = ($urandom_range(3, 0) == 0);
      exp_mi = m_hold_full ? m_hold : dflt();
      m_hold_full = 1'b0;
      if (rd_last) m_valid = 1'b0;
      exp_ov = m_valid ? 1 : 0;
      if (!m_valid) begin m_rx = mo; m_valid = 1'b1; end
      ov0 = ov_cnt;
      frame(mo, rd_last, mi);
      total++; if (mi !== exp_mi) begin bad++; $display("FAIL rand_miso it=%0d got %h exp %h", it, mi, exp_mi); end
      total++; if (bus.rx_data !== m_rx) begin bad++; $display("FAIL rand_rx_data it=%0d got %h exp %h", it, bus.rx_data, m_rx); end
      total++; if (bus.rx_valid !== m_valid) begin bad++; $display("FAIL rand_rx_valid it=%0d got %b exp %b", it, bus.rx_valid, m_valid); end
      total++; if (ov_cnt - ov0 !== exp_ov) begin bad++; $display("FAIL rand_overrun it=%0d got %0d exp %0d", it, ov_cnt - ov0, exp_ov); end
      if ($urandom_range(1, 0) == 1) begin read_rx(); m_valid = 1'b0; end
    end
    read_rx();
  endtask

  initial begin
    bus.sck = 1'b0; bus.cs_n = 1'b1; bus.mosi = 1'b0;
    bus.tx_data = '0; bus.tx_wr = 1'b0; bus.rx_rd = 1'b0;
    test_reset();
    test_single();
    test_empty_tx();
    test_overrun();
    test_back_to_back();
    test_abort();
    test_reset_midframe();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
